// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl: register-mapped bank of 8-bit LED lanes with per-bit blink
// masking, a global enable and a free-running blink timebase.
//
// Address map (N = NUM_BYTES):
//   0 .. N-1    data lane k
//   N .. 2N-1   blink mask lane k (1 = this bit blinks)
//   2N          blink period (8 bit)
//   2N+1        control: bit0 enable (stored), bit1 clear-all-data (not stored)
//   2N+2        duty (4 bit), only when LED_BANK_PWM_EN is defined
//
// Optional feature: define LED_BANK_PWM_EN to compile in 16-step brightness
// control (duty register plus a free-running 4-bit pwm counter). Without it,
// address 2N+2 behaves like any other unmapped address.

module led_bank_ctrl #(
   parameter int NUM_BYTES = 3,
   parameter int PRESCALE  = 50000,
   parameter int ADDR_W    = 3
) (
   input  logic                   ledclk,
   input  logic                   ledrst,
   input  logic                   ledcs,
   input  logic                   ledwrite,
   input  logic [ADDR_W-1:0]      ledaddr,
   input  logic [7:0]             ledinputdata,
   output logic [8*NUM_BYTES-1:0] ledout
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

   localparam logic [31:0] PERIOD_ADDR  = 32'(2 * NUM_BYTES);
   localparam logic [31:0] CONTROL_ADDR = 32'(2 * NUM_BYTES + 1);
`ifdef LED_BANK_PWM_EN
   localparam logic [31:0] DUTY_ADDR    = 32'(2 * NUM_BYTES + 2);
`endif

   // register file
   logic [NUM_BYTES-1:0][7:0] datareg;
   logic [NUM_BYTES-1:0][7:0] maskreg;
   logic [7:0]                periodreg;
   logic                      enable;

   // blink timebase
   logic [PW-1:0]             prescnt;
   logic [7:0]                blinkcnt;
   logic                      phase;
   logic                      tick;

   // write decode
   logic [31:0]               addrx;
   logic                      wren;
   logic [NUM_BYTES-1:0]      datawe;
   logic [NUM_BYTES-1:0]      maskwe;
   logic                      periodwe;
   logic                      controlwe;
   logic                      clearcmd;

   // brightness gate applied to every output bit
   logic                      pwmon;

   assign addrx     = 32'(ledaddr);
   assign wren      = ledcs & ledwrite;
   assign periodwe  = wren && (addrx == PERIOD_ADDR);
   assign controlwe = wren && (addrx == CONTROL_ADDR);
   assign clearcmd  = controlwe & ledinputdata[1];
   assign tick      = (prescnt == PRESCALE_LAST);

   // Per-lane write enables; unmapped addresses match nothing and are dropped.
   always_comb begin
      datawe = '0;
      maskwe = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         datawe[k] = wren && (addrx == 32'(k));
         maskwe[k] = wren && (addrx == 32'(NUM_BYTES + k));
      end
   end

   // Data and mask lanes; the clear command overrides a data write on that edge.
   always_ff @(posedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         datareg <= '0;
         maskreg <= '0;
      end else begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (clearcmd) begin
               datareg[k] <= 8'h00;
            end else if (datawe[k]) begin
               datareg[k] <= ledinputdata;
            end
            if (maskwe[k]) begin
               maskreg[k] <= ledinputdata;
            end
         end
      end
   end

   // Blink period and global enable; control bit1 is a pulse and is not kept.
   always_ff @(posedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         periodreg <= 8'h0F;
         enable    <= 1'b1;
      end else begin
         if (periodwe) begin
            periodreg <= ledinputdata;
         end
         if (controlwe) begin
            enable <= ledinputdata[0];
         end
      end
   end

   // Free-running prescaler and blink counter; a period write restarts timing but keeps phase.
   always_ff @(posedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         prescnt  <= '0;
         blinkcnt <= 8'h00;
         phase    <= 1'b0;
      end else if (periodwe) begin
         prescnt  <= '0;
         blinkcnt <= 8'h00;
      end else begin
         if (tick) begin
            prescnt <= '0;
            if (blinkcnt == periodreg) begin
               blinkcnt <= 8'h00;
               phase    <= ~phase;
            end else begin
               blinkcnt <= blinkcnt + 8'd1;
            end
         end else begin
            prescnt <= prescnt + PW'(1);
         end
      end
   end

`ifdef LED_BANK_PWM_EN
   logic [3:0] dutyreg;
   logic [3:0] pwmcnt;
   logic       dutywe;

   assign dutywe = wren && (addrx == DUTY_ADDR);

   // Duty register and free-running 4-bit pwm counter.
   always_ff @(posedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         dutyreg <= 4'hF;
         pwmcnt  <= 4'h0;
      end else begin
         pwmcnt <= pwmcnt + 4'd1;
         if (dutywe) begin
            dutyreg <= ledinputdata[3:0];
         end
      end
   end

   assign pwmon = (dutyreg == 4'hF) || (pwmcnt < dutyreg);
`else
   assign pwmon = 1'b1;
`endif

   // Output decode straight from registers so a write shows up right after its edge.
   always_comb begin
      ledout = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         ledout[8*k +: 8] = {8{enable & pwmon}} & datareg[k] & (~maskreg[k] | {8{phase}});
      end
   end

endmodule

// File: tb/tb_led_bank_ctrl.sv
// tb_led_bank_ctrl: scoreboard bench for led_bank_ctrl (NUM_BYTES=2,
// PRESCALE=4, ADDR_W=3). The driver computes the expected ledout for every
// clock edge from a cycle-counting reference model and queues it; a monitor
// pops and compares one entry after each rising edge.
// Honours LED_BANK_PWM_EN the same way the design does.

module tb_led_bank_ctrl;

   localparam int NB  = 2;
   localparam int PRE = 4;
   localparam int AW  = 3;

   logic              ledclk;
   logic              ledrst;
   logic              ledcs;
   logic              ledwrite;
   logic [AW-1:0]     ledaddr;
   logic [7:0]        ledinputdata;
   logic [8*NB-1:0]   ledout;

   int total = 0;
   int bad   = 0;

   logic [15:0] expq[$];

   // reference model state
   logic [7:0] mdata[NB];
   logic [7:0] mmask[NB];
   logic [7:0] mperiod;
   logic       men;
   logic       mphase;
   logic [3:0] mduty;
   int         melapsed;
   int         medges;

   led_bank_ctrl #(
      .NUM_BYTES(NB),
      .PRESCALE (PRE),
      .ADDR_W   (AW)
   ) dut (
      .ledclk      (ledclk),
      .ledrst      (ledrst),
      .ledcs       (ledcs),
      .ledwrite    (ledwrite),
      .ledaddr     (ledaddr),
      .ledinputdata(ledinputdata),
      .ledout      (ledout)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial ledclk = 1'b0;
   always #5 ledclk = ~ledclk;

   task automatic checkOutput(input string name, input logic [15:0] want);
      total++;
      if (ledout !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h t=%0t", name, ledout, want, $time);
      end
   endtask

   task automatic modelReset();
      foreach (mdata[k]) mdata[k] = 8'h00;
      foreach (mmask[k]) mmask[k] = 8'h00;
      mperiod  = 8'h0F;
      men      = 1'b1;
      mphase   = 1'b0;
      mduty    = 4'hF;
      melapsed = 0;
      medges   = 0;
   endtask

   // One clock edge of the reference: apply the write, then advance time.
   task automatic modelStep(input logic cs, input logic wr, input logic [2:0] addr, input logic [7:0] d);
      bit perw;
      perw = 0;
      if (cs && wr) begin
         case (addr)
            3'd0: mdata[0] = d;
            3'd1: mdata[1] = d;
            3'd2: mmask[0] = d;
            3'd3: mmask[1] = d;
            3'd4: begin mperiod = d; perw = 1; end
            3'd5: begin
               men = d[0];
               if (d[1]) foreach (mdata[k]) mdata[k] = 8'h00;
            end
`ifdef LED_BANK_PWM_EN
            3'd6: mduty = d[3:0];
`endif
            default: ;
         endcase
      end
      medges++;
      if (perw) begin
         melapsed = 0;
      end else begin
         melapsed++;
         if (melapsed % ((int'(mperiod) + 1) * PRE) == 0) mphase = ~mphase;
      end
   endtask

   function automatic logic [15:0] modelOut();
      logic [15:0] r;
      bit pwm;
`ifdef LED_BANK_PWM_EN
      pwm = (mduty == 4'hF) || ((medges % 16) < int'(mduty));
`else
      pwm = 1;
`endif
      r = '0;
      for (int k = 0; k < NB; k++)
         for (int j = 0; j < 8; j++)
            r[8*k+j] = men && mdata[k][j] && (!mmask[k][j] || mphase) && pwm;
      return r;
   endfunction

   // Drive inputs for the coming edge and queue the expected result.
   task automatic driveNow(input logic cs, input logic wr, input logic [2:0] addr, input logic [7:0] d);
      ledcs        = cs;
      ledwrite     = wr;
      ledaddr      = addr;
      ledinputdata = d;
      modelStep(cs, wr, addr, d);
      expq.push_back(modelOut());
   endtask

   task automatic applyStimulus(input logic cs, input logic wr, input logic [2:0] addr, input logic [7:0] d);
      @(negedge ledclk);
      driveNow(cs, wr, addr, d);
   endtask

   // Reset pulsed and released inside the low phase, no edge seen.
   task automatic resetPulse();
      @(negedge ledclk);
      ledrst = 1'b1;
      #1;
      checkOutput("rst_pulse_immediate", 16'h0000);
      modelReset();
      #1;
      ledrst = 1'b0;
      driveNow(1'b1, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom));
   endtask

   // Reset held across an edge with a write presented; the write must be lost.
   task automatic resetHeld();
      @(negedge ledclk);
      ledrst       = 1'b1;
      ledcs        = 1'b1;
      ledwrite     = 1'b1;
      ledaddr      = 3'($urandom_range(0, 1));
      ledinputdata = 8'hFF;
      #1;
      checkOutput("rst_held_immediate", 16'h0000);
      modelReset();
      expq.push_back(modelOut());
      @(negedge ledclk);
      ledrst = 1'b0;
      driveNow(1'b1, 1'b1, 3'($urandom_range(0, 1)), 8'($urandom));
   endtask

   // Monitor: one scoreboard comparison after every rising edge with a pending entry.
   initial begin
      logic [15:0] want;
      forever begin
         @(posedge ledclk);
         #1;
         if (expq.size() > 0) begin
            want = expq.pop_front();
            checkOutput("scoreboard", want);
         end
      end
   end

   // Driver: directed boundary cases, then randomized traffic.
   initial begin
      logic [2:0] a;
      logic [7:0] d;
      int r;
      ledrst       = 1'b0;
      ledcs        = 1'b0;
      ledwrite     = 1'b0;
      ledaddr      = '0;
      ledinputdata = '0;
      modelReset();
      #1;
      ledrst = 1'b1;
      @(negedge ledclk);
      checkOutput("reset_state", 16'h0000);
      ledrst = 1'b0;

      driveNow(1'b1, 1'b1, 3'd0, 8'hA5);
      applyStimulus(1'b1, 1'b1, 3'd1, 8'h3C);
      @(posedge ledclk); #2;
      checkOutput("two_lanes", 16'h3CA5);
      applyStimulus(1'b1, 1'b1, 3'd7, 8'h55);
      @(posedge ledclk); #2;
      checkOutput("unmapped_write", 16'h3CA5);

      applyStimulus(1'b1, 1'b1, 3'd0, 8'hFF);
      applyStimulus(1'b1, 1'b1, 3'd2, 8'h0F);
      applyStimulus(1'b1, 1'b1, 3'd4, 8'h01);
      @(posedge ledclk); #2;
      checkOutput("blink_first_off", 16'h3CF0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
      @(posedge ledclk); #2;
      checkOutput("blink_on_after_8", 16'h3CFF);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);

      applyStimulus(1'b1, 1'b1, 3'd5, 8'h00);
      @(posedge ledclk); #2;
      checkOutput("enable_off", 16'h0000);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
      applyStimulus(1'b1, 1'b1, 3'd5, 8'h01);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
      applyStimulus(1'b1, 1'b1, 3'd5, 8'h03);
      @(posedge ledclk); #2;
      checkOutput("clear_cmd", 16'h0000);

      applyStimulus(1'b1, 1'b1, 3'd0, 8'hFF);
      applyStimulus(1'b1, 1'b1, 3'd6, 8'h04);
      for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
      applyStimulus(1'b1, 1'b1, 3'd6, 8'h00);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
      applyStimulus(1'b1, 1'b1, 3'd6, 8'h0F);

      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 199));
         if (r == 0) begin
            resetPulse();
         end else if (r == 1) begin
            resetHeld();
         end else begin
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if (a == 3'd4 && $urandom_range(0, 9) != 0) d = 8'($urandom_range(0, 3));
            if (a == 3'd5) begin
               d[0] = ($urandom_range(0, 9) != 0);
               d[1] = ($urandom_range(0, 9) == 0);
            end
            applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 5), a, d);
         end
      end

      for (int i = 0; i < 6 && expq.size() > 0; i++) @(negedge ledclk);
      if (expq.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain pending=%0d want=0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
